// File: rtl/mult_hilo_ctrl.sv
// rtl/mult_hilo_ctrl.sv - issue/retire controller for the iterative 32x32 multiplier with HI/LO registers
//
// Accepts a multiply request in IDLE, drives the multiplier operands and control
// (held stable for the whole iteration), waits LAT edges, then captures the
// multiplier result into the architectural HI/LO registers. HI/LO can also be
// written directly while idle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, op_a, op_b    multiply request and operands (sampled only when ready)
//   mode                 signedness code, forwarded to m_ctrl[1:0]
//   wr_hi, wr_lo, wr_data  direct HI/LO writes (honoured only when ready)
//   ready, busy, done    idle flag, in-flight flag, one-cycle post-capture pulse
//   hi, lo               architectural HI/LO registers
//   m_a, m_b, m_ctrl     multiplier inputs
//   m_higher, m_lower    multiplier result
module mult_hilo_ctrl #(
  parameter int LAT   = 35,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [1:0]  mode,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] m_a,
  output logic [31:0] m_b,
  output logic [4:0]  m_ctrl,
  input  logic [31:0] m_higher,
  input  logic [31:0] m_lower
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      m_a    <= '0;
      m_b    <= '0;
      m_ctrl <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Writes on the same edge as an accepted start still land; the
          // later capture simply overwrites them.
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start) begin
            m_a    <= op_a;
            m_b    <= op_b;
            // Flipping bit 4 forces an input change so the multiplier restarts
            // even when operands and mode repeat.
            m_ctrl <= {~m_ctrl[4], 2'b00, mode};
            count  <= CNT_W'(1);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          count <= count + CNT_W'(1);
          if (count == CNT_LAST) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          hi    <= m_higher;
          lo    <= m_lower;
          done  <= 1'b1;
          count <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded from the state register only: no combinational path from start.
  assign ready = (state == S_IDLE);
  assign busy  = ~ready;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb/tb_mult_hilo_ctrl.sv - directed self-checking bench for mult_hilo_ctrl
module tb_mult_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic [1:0]  mode;
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        ready, busy, done;
  logic [31:0] hi, lo, m_a, m_b;
  logic [4:0]  m_ctrl;
  logic [31:0] m_higher, m_lower;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_hilo_ctrl #(.LAT(35), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .mode(mode), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .ready(ready), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .m_a(m_a), .m_b(m_b), .m_ctrl(m_ctrl),
    .m_higher(m_higher), .m_lower(m_lower)
  );

  // Multiplier stand-in: result is garbage until inputs have been stable long
  // enough, so an early capture reads a wrong value. mode 00 is signed.
  logic [31:0] prev_a, prev_b;
  logic [4:0]  prev_ctrl;
  int          settle = 0;
  logic [63:0] prod;

  always @(posedge clk) begin
    if ({m_a, m_b, m_ctrl} !== {prev_a, prev_b, prev_ctrl}) settle <= 0;
    else if (settle < 100) settle <= settle + 1;
    prev_a    <= m_a;
    prev_b    <= m_b;
    prev_ctrl <= m_ctrl;
  end

  always_comb begin
    prod = 64'hDEADBEEF_DEADBEEF;
    if (settle >= 33) begin
      if (m_ctrl[1:0] == 2'b00)
        prod = {{32{m_a[31]}}, m_a} * {{32{m_b[31]}}, m_b};
      else
        prod = {32'b0, m_a} * {32'b0, m_b};
    end
  end

  assign m_higher = prod[63:32];
  assign m_lower  = prod[31:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one multiply and returns on the done cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] md,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic [4:0] ectrl, input string tag);
    int n;
    op_a = a; op_b = b; mode = md; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_mctrl"}, m_ctrl, ectrl);
    chk({tag, "_ma"}, m_a, a);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_busy_len"}, n, 35);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask

  initial begin
    int n;
    int done_seen;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; mode = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    tick(); tick();
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_mctrl", m_ctrl, 0);
    chk("rst_ma", m_a, 0);
    rst_n = 1'b1;
    tick();

    do_op(32'h7, 32'hFFFFFFFD, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFEB, 5'b10000, "t1");
    tick();
    chk("t1_done_clr", done, 0);
    chk("t1_hi_hold", hi, 32'hFFFFFFFF);

    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFE, 32'h00000001, 5'b00011, "t2");
    tick();

    // Second start issued on the done cycle of the first.
    do_op(32'h3, 32'h5, 2'b11, 32'h0, 32'hF, 5'b10011, "t3a");
    do_op(32'h3, 32'h5, 2'b11, 32'h0, 32'hF, 5'b00011, "t3b");
    tick();
    chk("t3_done_clr", done, 0);

    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hA5A5A5A5;
    tick();
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("wr_hi", hi, 32'hA5A5A5A5);
    chk("wr_lo", lo, 32'hA5A5A5A5);
    chk("wr_done", done, 0);
    chk("wr_ready", ready, 1);

    // Start with a same-edge LO write, then interfere while busy.
    op_a = 32'h2; op_b = 32'h3; mode = 2'b11; start = 1'b1;
    wr_lo = 1'b1; wr_data = 32'h12345678;
    tick();
    start = 1'b0; wr_lo = 1'b0;
    chk("t4_lo_wr", lo, 32'h12345678);
    chk("t4_mctrl", m_ctrl, 5'b10011);
    n = 0;
    repeat (5) begin tick(); n++; end
    start = 1'b1; op_a = 32'h9; wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0BAD0BAD;
    tick(); n++;
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    chk("t4_ma_hold", m_a, 32'h2);
    chk("t4_hi_ign", hi, 32'hA5A5A5A5);
    chk("t4_lo_ign", lo, 32'h12345678);
    chk("t4_busy", busy, 1);
    while (busy && n < 100) begin tick(); n++; end
    chk("t4_busy_len", n, 35);
    chk("t4_done", done, 1);
    chk("t4_hi", hi, 32'h0);
    chk("t4_lo", lo, 32'h6);
    tick();

    // Reset in the middle of WAIT.
    op_a = 32'h4; op_b = 32'h4; mode = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ready", ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_hi", hi, 0);
    chk("t5_lo", lo, 0);
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    repeat (45) begin
      tick();
      if (done) done_seen++;
    end
    chk("t5_no_done", done_seen, 0);
    chk("t5_lo_hold", lo, 0);
    chk("t5_ready_end", ready, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
